// File: rtl/lut_layer_pkg.sv
// Shared definitions for the LUT layer pipeline.
//   state_e       : control FSM states (run / drain / load)
//   cfg_neuron_w  : width of the neuron-select field for a given neuron count (min 1)
//   CFG_NEURON_W  : neuron-select width for the default four-neuron layer
package lut_layer_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StLoad  = 2'd2
    } state_e;

    function automatic int unsigned cfg_neuron_w(input int unsigned neurons);
        return (neurons > 1) ? $clog2(neurons) : 1;
    endfunction

    localparam int unsigned CFG_NEURON_W = cfg_neuron_w(4);

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron's lookup table held in flops, with write decode and read mux.
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry)
//   we         : write strobe, already qualified by the owning layer
//   waddr/wdata: write address and data
//   raddr      : lookup address
//   rdata      : combinational table[raddr]
module lut_neuron_ram #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int unsigned Depth = 2 ** IN_BITS;

    logic [OUT_BITS-1:0] mem_q [Depth];
    logic [OUT_BITS-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/lut_layer_pipe.sv
// Layer of NEURONS independent LUT neurons behind a one-stage valid/ready pipeline.
// Tables are reprogrammed through a request/grant window that only opens once the
// output stage is empty, so no result is ever formed from a half-written table.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/valid/ready  : lookup addresses, neuron n at [n*IN_BITS +: IN_BITS]
//   out_data/valid/ready : results, neuron n at [n*OUT_BITS +: OUT_BITS]
//   cfg_req/cfg_gnt      : programming request / window open
//   cfg_we, cfg_neuron, cfg_addr, cfg_wdata : table write, honoured only while granted
module lut_layer_pipe
    import lut_layer_pkg::*;
#(
    parameter int unsigned NEURONS  = 4,
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NEURONS*IN_BITS-1:0]          in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [NEURONS*OUT_BITS-1:0]         out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    input  logic                                cfg_req,
    output logic                                cfg_gnt,
    input  logic                                cfg_we,
    input  logic [cfg_neuron_w(NEURONS)-1:0]    cfg_neuron,
    input  logic [IN_BITS-1:0]                  cfg_addr,
    input  logic [OUT_BITS-1:0]                 cfg_wdata
);

    state_e                      state_q, state_d;
    logic                        out_valid_q, out_valid_d;
    logic [NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
    logic [NEURONS*OUT_BITS-1:0] lut_rd;
    logic                        accept;
    logic                        tbl_we;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort in DRAIN takes priority over the grant
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (cfg_req) state_d = StDrain;
            StDrain: begin
                if (!cfg_req) begin
                    state_d = StRun;
                end else if (!out_valid_q) begin
                    state_d = StLoad;
                end
            end
            StLoad:  if (!cfg_req) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
        cfg_gnt  = (state_q == StLoad);
        tbl_we   = (state_q == StLoad) && cfg_we && (32'(cfg_neuron) < NEURONS);
    end

    for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
        logic we_n;
        assign we_n = tbl_we && (32'(cfg_neuron) == n);

        lut_neuron_ram #(
            .IN_BITS (IN_BITS),
            .OUT_BITS(OUT_BITS)
        ) u_ram (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (we_n),
            .waddr(cfg_addr),
            .wdata(cfg_wdata),
            .raddr(in_data[n*IN_BITS +: IN_BITS]),
            .rdata(lut_rd[n*OUT_BITS +: OUT_BITS])
        );
    end

    // Output stage
    always_comb begin
        accept      = in_valid && in_ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lut_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/lut_layer_pipe.md
LUT_LAYER_PIPE -- requirements
Module: lut_layer_pipe

Interface
REQ-001 SHALL have parameter NEURONS, default 4, number of independent LUT neurons.
REQ-002 SHALL have parameter IN_BITS, default 8, address width per neuron (table depth 2^IN_BITS).
REQ-003 SHALL have parameter OUT_BITS, default 2, output width per neuron.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_data  input  NEURONS*IN_BITS  neuron n address at slice [n*IN_BITS +: IN_BITS].
REQ-007 SHALL have port in_valid / in_ready  input / output  1 each  input handshake.
REQ-008 SHALL have port out_data  output  NEURONS*OUT_BITS  neuron n result at slice [n*OUT_BITS +: OUT_BITS].
REQ-009 SHALL have port out_valid / out_ready  output / input  1 each  output handshake.
REQ-010 SHALL have port cfg_req  input  1  request table programming.
REQ-011 SHALL have port cfg_gnt  output  1  programming window open.
REQ-012 SHALL have port cfg_we, cfg_neuron, cfg_addr, cfg_wdata  input  1, clog2(NEURONS) (min 1), IN_BITS, OUT_BITS  table write.

Function
REQ-013 SHALL hold one OUT_BITS x 2^IN_BITS table per neuron in flops.
REQ-014 SHALL have FSM states RUN, DRAIN, LOAD; reset state RUN.
REQ-015 SHALL go RUN->DRAIN when cfg_req=1.
REQ-016 SHALL go DRAIN->LOAD in the first cycle out_valid=0, covering DRAIN entered with an empty stage.
REQ-017 SHALL drive cfg_gnt=1 only in LOAD.
REQ-018 SHALL go LOAD->RUN when cfg_req=0.
REQ-019 SHALL go DRAIN->RUN when cfg_req drops during DRAIN, with no table write.
REQ-020 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-021 SHALL, on in_valid && in_ready, register each neuron's table[in_data slice] into out_data and set out_valid next cycle: latency 1, throughput 1/cycle.
REQ-022 SHALL hold out_data stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid on out_ready without a new accept.
REQ-024 SHALL apply cfg_we only in LOAD, writing table[cfg_neuron][cfg_addr]=cfg_wdata at the clock edge; cfg_we outside LOAD or with cfg_neuron>=NEURONS is ignored.
REQ-025 SHALL never change a table during RUN or DRAIN, so results are never computed from a partially programmed table.
REQ-026 SHALL make a LOAD write visible to the first lookup accepted after returning to RUN.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set state=RUN, out_valid=0, out_data=0, cfg_gnt=0, and every table entry=0, so an unprogrammed layer outputs all zeros.
REQ-028 SHALL discard an in-flight result and any LOAD window on reset mid-operation, with no partial write.
REQ-029 SHALL require no extra cycles after rst_n release; in_ready=1 in the first cycle.

Structure
REQ-030 SHALL place the FSM state enum and a CFG_NEURON_W helper constant in shared package lut_layer_pkg.
REQ-031 SHALL contain one sub-module, lut_neuron_ram (one table plus write decode and read mux), instantiated NEURONS times; handshake and FSM stay in lut_layer_pipe.

Verification
REQ-032 SHALL cover reset lookup: after reset, in_data=0xFF_00_A5_3C with in_valid=1 -> next cycle out_valid=1, out_data=0.
REQ-033 SHALL cover program/read: write neuron2 addr 0xA5=2'b11 and neuron0 addr 0x3C=2'b01, release cfg_req, send 0xFF_A5_00_3C -> out_data=8'b00_11_00_01 one cycle after accept.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles over a 3-beat stream -> one result held stable, in_ready=0, no loss or duplication; order preserved after release.
REQ-035 SHALL cover drain-before-grant: cfg_req raised while out_valid=1 and out_ready=0 -> cfg_gnt stays 0 until the result is consumed; cfg_we during DRAIN has no effect.
REQ-036 SHALL cover abort and reset: cfg_req pulse of 1 cycle during DRAIN returns to RUN with tables unchanged; rst_n asserted in LOAD -> all entries 0, state RUN.
REQ-037 SHALL cover parameter sweep: NEURONS=1, IN_BITS=4, OUT_BITS=3, random programming checked against a reference model for 1000 beats with random out_ready.
